// File: rtl/ps2_kbd_ctrl_if.sv
// Receiver FIFO pop handshake between the PS/2 receiver (master) and ps2_kbd_ctrl (slave).
interface ps2_kbd_ctrl_if;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       nextdata_n;

  modport master (output kbd_ready, output kbd_data, output kbd_overflow, input nextdata_n);
  modport slave  (input kbd_ready, input kbd_data, input kbd_overflow, output nextdata_n);
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: pops scan bytes, parses E0/F0 prefixes, emits key events.
// Optional typematic repeat suppression: define PS2_TYPEMATIC_FILTER_EN.
module ps2_kbd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             resetn,
  ps2_kbd_ctrl_if.slave    kbd,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow,
  output logic             err_timeout,
  input  logic             clr_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_SETTLE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_b;
  logic             r_ext_pend;
  logic             r_brk_pend;
  logic [TW-1:0]    r_tmo_cnt;
  logic [7:0]       r_evt_code;
  logic             r_evt_ext;
  logic             r_evt_break;
  logic             r_key_down;
  logic [7:0]       r_held_code;
  logic             r_held_ext;
  logic [CNT_W-1:0] r_press_count;
  logic             r_err_overflow;
  logic             r_err_timeout;

  logic w_pop;
  logic w_is_ext;
  logic w_is_brk;
  logic w_is_disc;
  logic w_is_key;
  logic w_match;
  logic w_emit;
  logic w_make;
  logic w_brk_evt;
  logic w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE:   if (kbd.kbd_ready) w_state_nxt = S_POP;
      S_POP: begin
        w_pop       = 1'b1;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_is_ext  = (r_b == 8'hE0);
    w_is_brk  = (r_b == 8'hF0);
    w_is_disc = 1'b0;
    case (r_b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: w_is_disc = 1'b1;
      default:                                         w_is_disc = 1'b0;
    endcase
    w_is_key = !w_is_ext && !w_is_brk && !w_is_disc;
    w_match  = ({r_ext_pend, r_b} == {r_held_ext, r_held_code});
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic w_repeat;
  assign w_repeat = !r_brk_pend && r_key_down && w_match;
  assign w_emit   = w_pop && w_is_key && !w_repeat;
`else
  assign w_emit   = w_pop && w_is_key;
`endif

  assign w_make    = w_emit && !r_brk_pend;
  assign w_brk_evt = w_emit && r_brk_pend;
  assign w_tmo     = (r_ext_pend || r_brk_pend) && !w_pop && (r_tmo_cnt == TMO_LAST);

  // Event fields are shown live from the byte register during the pulse, then held;
  // gating with resetn keeps a byte caught by reset in its pop cycle from surfacing.
  assign kbd.nextdata_n = !w_pop;
  assign evt_valid      = w_emit && resetn;
  assign evt_code       = evt_valid ? r_b        : r_evt_code;
  assign evt_ext        = evt_valid ? r_ext_pend : r_evt_ext;
  assign evt_break      = evt_valid ? r_brk_pend : r_evt_break;
  assign key_down       = r_key_down;
  assign held_code      = r_held_code;
  assign held_ext       = r_held_ext;
  assign press_count    = r_press_count;
  assign err_overflow   = r_err_overflow;
  assign err_timeout    = r_err_timeout;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_b            <= '0;
      r_ext_pend     <= 1'b0;
      r_brk_pend     <= 1'b0;
      r_tmo_cnt      <= '0;
      r_evt_code     <= '0;
      r_evt_ext      <= 1'b0;
      r_evt_break    <= 1'b0;
      r_key_down     <= 1'b0;
      r_held_code    <= '0;
      r_held_ext     <= 1'b0;
      r_press_count  <= '0;
      r_err_overflow <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && kbd.kbd_ready) r_b <= kbd.kbd_data;

      if (w_pop) begin
        r_tmo_cnt <= '0;
        if (w_is_ext) begin
          r_ext_pend <= 1'b1;
        end else if (w_is_brk) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end else if (r_ext_pend || r_brk_pend) begin
        if (w_tmo) begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
          r_tmo_cnt  <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end else begin
        r_tmo_cnt <= '0;
      end

      if (w_emit) begin
        r_evt_code  <= r_b;
        r_evt_ext   <= r_ext_pend;
        r_evt_break <= r_brk_pend;
      end

      if (w_make) begin
        r_key_down    <= 1'b1;
        r_held_code   <= r_b;
        r_held_ext    <= r_ext_pend;
        r_press_count <= r_press_count + 1'b1;
      end else if (w_brk_evt && w_match) begin
        r_key_down <= 1'b0;
      end

      if (kbd.kbd_overflow) r_err_overflow <= 1'b1;
      else if (clr_err)     r_err_overflow <= 1'b0;

      if (w_tmo)        r_err_timeout <= 1'b1;
      else if (clr_err) r_err_timeout <= 1'b0;
    end
  end

endmodule
